// File: rtl/picorv_irq_ctrl.sv
// rtl/picorv_irq_ctrl.sv - multi-channel interrupt generator driving picorv32 irq[] and tracking eoi[]
module picorv_irq_ctrl #(
    parameter int NUM_IRQ = 32,
    parameter int TIMEOUT_W = 16,
    parameter logic [NUM_IRQ-1:0] LEVEL_MASK = '0,
    localparam int ID_W = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 req_valid,
    input  logic [ID_W-1:0]      req_id,
    output logic                 req_ready,
    input  logic [NUM_IRQ-1:0]   enable,
    input  logic [TIMEOUT_W-1:0] timeout_limit,
    output logic [NUM_IRQ-1:0]   irq,
    input  logic [NUM_IRQ-1:0]   eoi,
    input  logic [NUM_IRQ-1:0]   err_clr,
    output logic [NUM_IRQ-1:0]   timeout_err,
    output logic [NUM_IRQ-1:0]   busy
);

    typedef enum logic [1:0] {S_IDLE, S_ASSERT, S_SERVICE} state_t;

    logic [NUM_IRQ-1:0] queued;

    // Out-of-range ids are accepted and simply match no channel.
    always_comb begin
        req_ready = 1'b1;
        if (32'(req_id) < NUM_IRQ) req_ready = ~queued[req_id];
    end

    for (genvar i = 0; i < NUM_IRQ; i++) begin : g_ch
        state_t               state;
        logic [TIMEOUT_W-1:0] cnt;
        logic [TIMEOUT_W-1:0] cnt_inc;
        logic                 irq_q;
        logic                 err_q;
        logic                 queued_q;
        logic                 hit;
        logic                 exiting;
        logic                 expire;

        assign hit     = req_valid && req_ready && (req_id == ID_W'(i)) && enable[i];
        assign exiting = ((state == S_ASSERT) && eoi[i]) || ((state == S_SERVICE) && !eoi[i]);
        assign cnt_inc = (&cnt) ? cnt : cnt + TIMEOUT_W'(1);
        // A regular exit on the same cycle takes precedence over the watchdog.
        assign expire  = (state != S_IDLE) && (timeout_limit != '0) &&
                         (cnt == timeout_limit - TIMEOUT_W'(1)) && !exiting;

        always_ff @(posedge clk) begin
            if (reset) begin
                state    <= S_IDLE;
                cnt      <= '0;
                irq_q    <= 1'b0;
                err_q    <= 1'b0;
                queued_q <= 1'b0;
            end else begin
                if (expire)
                    err_q <= 1'b1;
                else if (err_clr[i])
                    err_q <= 1'b0;

                case (state)
                    S_IDLE: begin
                        irq_q <= 1'b0;
                        cnt   <= '0;
                        if (queued_q) begin
                            queued_q <= 1'b0;
                            if (enable[i]) begin
                                state <= S_ASSERT;
                                irq_q <= 1'b1;
                            end
                        end else if (hit) begin
                            state <= S_ASSERT;
                            irq_q <= 1'b1;
                        end
                    end
                    S_ASSERT: begin
                        cnt <= cnt_inc;
                        if (eoi[i]) begin
                            state <= S_SERVICE;
                            irq_q <= 1'b0;
                        end else if (expire) begin
                            state <= S_IDLE;
                            irq_q <= 1'b0;
                            cnt   <= '0;
                        end else begin
                            irq_q <= LEVEL_MASK[i];
                        end
                        if (hit) queued_q <= 1'b1;
                    end
                    S_SERVICE: begin
                        cnt   <= cnt_inc;
                        irq_q <= 1'b0;
                        if (!eoi[i] || expire) begin
                            state <= S_IDLE;
                            cnt   <= '0;
                        end
                        if (hit) queued_q <= 1'b1;
                    end
                    default: begin
                        state <= S_IDLE;
                        irq_q <= 1'b0;
                        cnt   <= '0;
                    end
                endcase
            end
        end

        assign irq[i]         = irq_q;
        assign timeout_err[i] = err_q;
        assign queued[i]      = queued_q;
        assign busy[i]        = (state != S_IDLE);
    end

endmodule
